// File: rtl/cpu7_icu_fetch_ctl.sv
// cpu7_icu_fetch_ctl: single-outstanding, 64-bit aligned instruction fetch controller between IFU and
// instruction memory. Define CPU7_ICU_LINEBUF_EN to add a one-line buffer that serves repeat fetches.
module cpu7_icu_fetch_ctl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int OFS_BITS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifu_icu_req_ic1,
  input  logic [ADDR_W-1:0] ifu_icu_addr_ic1,
  output logic              icu_ifu_ack_ic1,
  input  logic              ifu_icu_cancel,
  output logic [DATA_W-1:0] icu_ifu_data_ic2,
  output logic              icu_ifu_data_valid_ic2,
  input  logic              icu_inv,
  output logic              icu_mem_req,
  output logic [ADDR_W-1:0] icu_mem_addr,
  input  logic              mem_icu_gnt,
  input  logic [DATA_W-1:0] mem_icu_rdata,
  input  logic              mem_icu_rvalid
);

  localparam int TAG_W = ADDR_W - OFS_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN
`ifdef CPU7_ICU_LINEBUF_EN
    , S_HIT
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   tag_q;
  logic [DATA_W-1:0]  data_q;
  logic               dv_q;
  logic               deliver_mem;
  logic               deliver_hit;
  logic               lb_hit;
  logic               unused_bits;

`ifdef CPU7_ICU_LINEBUF_EN
  logic               lb_valid_q;
  logic [TAG_W-1:0]   lb_tag_q;
  logic [DATA_W-1:0]  lb_data_q;

  assign lb_hit      = lb_valid_q && (lb_tag_q == ifu_icu_addr_ic1[ADDR_W-1:OFS_BITS]);
  assign deliver_hit = (state_q == S_HIT) && !ifu_icu_cancel;
  assign unused_bits = ^ifu_icu_addr_ic1[OFS_BITS-1:0];
`else
  assign lb_hit      = 1'b0;
  assign deliver_hit = 1'b0;
  assign unused_bits = ^{icu_inv, ifu_icu_addr_ic1[OFS_BITS-1:0], lb_hit};
`endif

  // Ack is combinational so the IFU sees acceptance in the same cycle it raises req.
  assign icu_ifu_ack_ic1        = (state_q == S_IDLE) && ifu_icu_req_ic1 && !reset;
  assign icu_mem_req            = (state_q == S_REQ);
  assign icu_mem_addr           = {tag_q, {OFS_BITS{1'b0}}};
  assign icu_ifu_data_ic2       = data_q;
  assign icu_ifu_data_valid_ic2 = dv_q;

  // NOTE: every output of a combinational block gets a default first; a missed branch would infer a latch.
  always_comb begin
    state_d     = state_q;
    deliver_mem = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (icu_ifu_ack_ic1) begin
`ifdef CPU7_ICU_LINEBUF_EN
          state_d = lb_hit ? S_HIT : S_REQ;
`else
          state_d = S_REQ;
`endif
        end
      end
      S_REQ: begin
        if (mem_icu_gnt)         state_d = ifu_icu_cancel ? S_DRAIN : S_WAIT;
        else if (ifu_icu_cancel) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (mem_icu_rvalid) begin
          state_d     = S_IDLE;
          deliver_mem = !ifu_icu_cancel;
        end else if (ifu_icu_cancel) begin
          state_d = S_DRAIN;
        end
      end
      // The granted read still returns exactly one beat; swallow it.
      S_DRAIN: begin
        if (mem_icu_rvalid) state_d = S_IDLE;
      end
`ifdef CPU7_ICU_LINEBUF_EN
      S_HIT:   state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dv_q    <= deliver_mem || deliver_hit;
      if (icu_ifu_ack_ic1) tag_q <= ifu_icu_addr_ic1[ADDR_W-1:OFS_BITS];
      if (deliver_mem) data_q <= mem_icu_rdata;
`ifdef CPU7_ICU_LINEBUF_EN
      else if (deliver_hit) data_q <= lb_data_q;
`endif
    end
  end

`ifdef CPU7_ICU_LINEBUF_EN
  // Invalidate wins over a same-cycle fill.
  always_ff @(posedge clk) begin
    if (reset)            lb_valid_q <= 1'b0;
    else if (icu_inv)     lb_valid_q <= 1'b0;
    else if (deliver_mem) lb_valid_q <= 1'b1;
  end

  // NOTE: buffer tag/data carry no reset; they are only observed while lb_valid_q is set.
  always_ff @(posedge clk) begin
    if (deliver_mem) begin
      lb_tag_q  <= tag_q;
      lb_data_q <= mem_icu_rdata;
    end
  end
`endif

  mem_rvalid_in_window: assert property (@(posedge clk) disable iff (reset)
    mem_icu_rvalid |-> (state_q == S_WAIT || state_q == S_DRAIN));

endmodule

// File: tb/tb_cpu7_icu_fetch_ctl.sv
// Self-checking bench for cpu7_icu_fetch_ctl: transaction-level reference model with randomized delays,
// cancels and addresses; also covers the CPU7_ICU_LINEBUF_EN build when that macro is defined.
module tb_cpu7_icu_fetch_ctl;
  localparam int AW = 32;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          cancel = 1'b0;
  logic          inv = 1'b0;
  logic          gnt = 1'b0;
  logic          rvalid = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          ack, dv, mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] data;

  int total = 0;
  int bad = 0;
  int dv_cnt = 0;

  // Reference state: last delivered data and the line buffer contents as the IFU would see them.
  bit            lb_en;
  bit            lb_valid = 1'b0;
  logic [AW-4:0] lb_tag = '0;
  logic [DW-1:0] lb_data = '0;
  logic [DW-1:0] last_data = '0;

  cpu7_icu_fetch_ctl dut (
    .clk                    (clk),
    .reset                  (reset),
    .ifu_icu_req_ic1        (req),
    .ifu_icu_addr_ic1       (addr),
    .icu_ifu_ack_ic1        (ack),
    .ifu_icu_cancel         (cancel),
    .icu_ifu_data_ic2       (data),
    .icu_ifu_data_valid_ic2 (dv),
    .icu_inv                (inv),
    .icu_mem_req            (mem_req),
    .icu_mem_addr           (mem_addr),
    .mem_icu_gnt            (gnt),
    .mem_icu_rdata          (rdata),
    .mem_icu_rvalid         (rvalid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (dv === 1'b1) dv_cnt++;
  endtask

  // One complete fetch. mode: 0 none, 1 cancel in REQ, 2 cancel with gnt, 3 cancel in WAIT, 4 cancel with rvalid.
  task automatic do_fetch(input logic [AW-1:0] a, input logic [DW-1:0] rd_data,
                          input int gd, input int rd, input int mode, input bit inv_fill);
    logic [AW-1:0] al;
    bit hit, deliver;
    int dv0;
    if (mode == 1 && gd == 0) gd = 1;
    if (mode == 3 && rd == 0) rd = 1;
    al  = {a[AW-1:3], 3'b000};
    hit = lb_en && lb_valid && (lb_tag == a[AW-1:3]);
    dv0 = dv_cnt;
    req = 1'b1; addr = a; #1;
    total++;
    if (ack !== 1'b1) begin bad++; $display("FAIL fetch_ack addr=%h: got %b want 1", a, ack); end
    step();
    req = 1'b0; addr = $urandom;
    if (hit) begin
      total++;
      if (mem_req !== 1'b0 || dv !== 1'b0) begin
        bad++; $display("FAIL hit_no_mem: got req=%b dv=%b want 0/0", mem_req, dv);
      end
      step();
      total++;
      if (dv !== 1'b1 || data !== lb_data) begin
        bad++; $display("FAIL hit_data: got dv=%b data=%h want 1/%h", dv, data, lb_data);
      end
      total++;
      if (dv_cnt - dv0 != 1) begin bad++; $display("FAIL hit_count: got %0d want 1", dv_cnt - dv0); end
      last_data = lb_data;
      return;
    end
    total++;
    if (mem_req !== 1'b1 || mem_addr !== al) begin
      bad++; $display("FAIL mem_issue: got req=%b addr=%h want 1/%h", mem_req, mem_addr, al);
    end
    for (int i = 0; i < gd; i++) begin
      req = 1'b1; addr = $urandom; #1;
      total++;
      if (ack !== 1'b0) begin bad++; $display("FAIL stall_no_ack: got %b want 0", ack); end
      cancel = (mode == 1) && (i == gd - 1);
      step();
      req = 1'b0;
      if (cancel) begin
        cancel = 1'b0;
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL cancel_req_drop: got %b want 0", mem_req); end
        total++;
        if (dv_cnt != dv0 || data !== last_data) begin
          bad++; $display("FAIL cancel_req_nodata: got pulses=%0d data=%h want 0/%h", dv_cnt - dv0, data, last_data);
        end
        return;
      end
      total++;
      if (mem_req !== 1'b1 || mem_addr !== al) begin
        bad++; $display("FAIL stall_hold: got req=%b addr=%h want 1/%h", mem_req, mem_addr, al);
      end
    end
    gnt = 1'b1; cancel = (mode == 2);
    step();
    gnt = 1'b0; cancel = 1'b0;
    total++;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL grant_drop: got %b want 0", mem_req); end
    for (int i = 0; i < rd; i++) begin
      cancel = (mode == 3 && i == 0) || ((mode == 2 || mode == 3) && $urandom_range(1, 0) == 1);
      step();
      cancel = 1'b0;
    end
    rvalid = 1'b1; rdata = rd_data; cancel = (mode == 4); inv = inv_fill;
    step();
    rvalid = 1'b0; cancel = 1'b0; inv = 1'b0; rdata = {$urandom, $urandom};
    deliver = (mode == 0);
    total++;
    if (dv !== deliver) begin bad++; $display("FAIL rvalid_dv mode=%0d: got %b want %b", mode, dv, deliver); end
    total++;
    if (data !== (deliver ? rd_data : last_data)) begin
      bad++; $display("FAIL rvalid_data: got %h want %h", data, deliver ? rd_data : last_data);
    end
    total++;
    if (dv_cnt - dv0 != int'(deliver)) begin
      bad++; $display("FAIL deliver_count: got %0d want %0d", dv_cnt - dv0, int'(deliver));
    end
    if (deliver) begin
      last_data = rd_data;
      lb_valid  = !inv_fill;
      lb_tag    = a[AW-1:3];
      lb_data   = rd_data;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b1; addr = 32'h1c00_0010;
    step(); step();
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", ack); end
    total++;
    if (mem_req !== 1'b0 || mem_addr !== '0 || dv !== 1'b0 || data !== '0) begin
      bad++; $display("FAIL reset_outputs: got req=%b addr=%h dv=%b data=%h want 0/0/0/0", mem_req, mem_addr, dv, data);
    end
    reset = 1'b0; req = 1'b0;
    step();
  endtask

  task automatic test_single_fetch();
    do_fetch(32'h1c00_0004, 64'h0280_0000_0280_0000, 0, 0, 0, 1'b0);
  endtask

  task automatic test_grant_stall();
    do_fetch(32'h1c00_0040, 64'h1111_2222_3333_4444, 5, 0, 0, 1'b0);
  endtask

  task automatic test_cancel_before_grant();
    do_fetch(32'h1c00_0080, 64'hdead_0000_0000_beef, 2, 0, 1, 1'b0);
    do_fetch(32'h1c00_0100, 64'h0000_0100_0000_0100, 1, 1, 0, 1'b0);
  endtask

  task automatic test_cancel_after_grant();
    do_fetch(32'h1c00_0180, 64'hbad0_bad0_bad0_bad0, 0, 2, 3, 1'b0);
    do_fetch(32'h1c00_0200, 64'h0000_0200_0000_0200, 0, 1, 0, 1'b0);
    do_fetch(32'h1c00_0280, 64'hbad1_bad1_bad1_bad1, 1, 2, 2, 1'b0);
  endtask

  task automatic test_cancel_with_rvalid();
    do_fetch(32'h1c00_0300, 64'hbad2_bad2_bad2_bad2, 0, 1, 4, 1'b0);
    do_fetch(32'h1c00_0308, 64'h5555_6666_7777_8888, 0, 0, 0, 1'b0);
  endtask

  // Cancel in IDLE, and in the data_valid cycle, must leave delivered data untouched.
  task automatic test_cancel_idle();
    do_fetch(32'h1c00_0340, 64'h0123_4567_89ab_cdef, 0, 0, 0, 1'b0);
    cancel = 1'b1;
    step(); step();
    cancel = 1'b0;
    total++;
    if (dv !== 1'b0 || mem_req !== 1'b0 || data !== last_data) begin
      bad++; $display("FAIL cancel_idle: got dv=%b req=%b data=%h want 0/0/%h", dv, mem_req, data, last_data);
    end
    do_fetch(32'h1c00_0348, 64'hfedc_ba98_7654_3210, 1, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_fetch(32'h1c00_0380, 64'haaaa_0000_aaaa_0000, 0, 0, 0, 1'b0);
    total++;
    if (dv !== 1'b1) begin bad++; $display("FAIL b2b_dv_window: got %b want 1", dv); end
    do_fetch(32'h1c00_0388, 64'hbbbb_0000_bbbb_0000, 0, 0, 0, 1'b0);
    do_fetch(32'h1c00_0390, 64'hcccc_0000_cccc_0000, 1, 1, 0, 1'b0);
  endtask

  // With the buffer built in, repeats hit; otherwise every fetch goes to memory.
  task automatic test_linebuf();
    do_fetch(32'h1c00_0000, 64'h1c00_0000_0000_0001, 0, 0, 0, 1'b0);
    do_fetch(32'h1c00_0004, 64'h1c00_0000_0000_0002, 0, 0, 0, 1'b0);
    inv = 1'b1;
    step();
    inv = 1'b0; lb_valid = 1'b0;
    do_fetch(32'h1c00_0000, 64'h1c00_0000_0000_0003, 0, 0, 0, 1'b1);
    do_fetch(32'h1c00_0000, 64'h1c00_0000_0000_0004, 0, 0, 0, 1'b0);
    do_fetch(32'h1c00_0000, 64'h1c00_0000_0000_0005, 0, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    req = 1'b1; addr = 32'h1c00_0400; #1;
    total++;
    if (ack !== 1'b1) begin bad++; $display("FAIL reset_mid_ack: got %b want 1", ack); end
    step();
    req = 1'b0; gnt = 1'b1;
    step();
    gnt = 1'b0; reset = 1'b1;
    step();
    total++;
    if (mem_req !== 1'b0 || mem_addr !== '0 || dv !== 1'b0 || data !== '0) begin
      bad++; $display("FAIL reset_mid_outputs: got req=%b addr=%h dv=%b data=%h want 0/0/0/0", mem_req, mem_addr, dv, data);
    end
    reset = 1'b0; lb_valid = 1'b0; last_data = '0;
    step();
    do_fetch(32'h1c00_0408, 64'h9999_aaaa_bbbb_cccc, 0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      do_fetch(32'h1c00_0000 + ($urandom_range(7, 0) * 8) + $urandom_range(7, 0),
               {$urandom, $urandom}, $urandom_range(4, 0), $urandom_range(3, 0),
               $urandom_range(4, 0), $urandom_range(7, 0) == 0);
      if ($urandom_range(3, 0) == 0) step();
    end
  endtask

  initial begin
`ifdef CPU7_ICU_LINEBUF_EN
    lb_en = 1'b1;
`else
    lb_en = 1'b0;
`endif
    test_reset();
    test_single_fetch();
    test_grant_stall();
    test_cancel_before_grant();
    test_cancel_after_grant();
    test_cancel_with_rvalid();
    test_cancel_idle();
    test_back_to_back();
    test_linebuf();
    test_reset_mid();
    test_random();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
